sram_bridge: RTL and testbench
==============================

// Module: sram_bridge
// PURPOSE
//  Arbitrates the single 8-bit external SRAM port between the data_io download path (writer)
//  and the video fetch path (reader). Replaces the combinational ioctl/video mux at the top level.
//  Download bytes go into a small FIFO and drain into SRAM in write slots that never disturb
//  video reads, so an image can be loaded while the picture is displayed.
// PARAMETERS
//  DEPTH   8    FIFO entries, power of two, 2..32
//  AW      15   SRAM byte address width used (upper sramA bits tied 0 at top level)
// PORTS
//  clock       in   1    system clock (28 MHz); the only clock
//  reset       in   1    synchronous, active-high
//  ce          in   1    video pixel-fetch strobe, one cycle in every 4 clocks
//  ioctlB      in   1    download active
//  ioctlW      in   1    download byte strobe, one-cycle pulse
//  ioctlA      in   AW   download byte address
//  ioctlQ      in   8    download byte data
//  vidA        in   AW   video fetch address, sampled on ce
//  vidQ        out  8    video fetch data, valid from the cycle after the read phase ends
//  sramA       out  AW   SRAM address, registered
//  sramWe      out  1    SRAM write enable, active low, registered
//  sramOe      out  1    SRAM output enable, active low, registered
//  sramDo      out  8    SRAM write data
//  sramDoe     out  1    1 = drive sramDo onto the data bus (top level builds the tristate)
//  sramDi      in   8    SRAM read data
//  busy        out  1    ioctlB high or FIFO not empty
//  overflow    out  1    sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset values: vidQ=0, sramA=0, sramWe=1, sramOe=0, sramDo=0, sramDoe=0, busy=0, overflow=0;
//    FIFO flushed, phase=3. Reset mid-write deasserts sramWe/sramDoe on the next edge.
//  - 2-bit phase counter: phase <= 0 on cycle after ce, else phase+1 (saturating at 3).
//  - Phase 0,1 = READ: sramA=vidA latched at ce, sramOe=0, sramWe=1, sramDoe=0.
//    sramDi captured into vidQ at end of phase 1. Latency ce -> vidQ valid = 3 clocks.
//  - Phase 2,3 = WRITE slot, FSM: IDLE -> SETUP (phase 2, FIFO non-empty: sramA=head addr,
//    sramDo=head data, sramDoe=1, sramOe=1, sramWe=0) -> HOLD (phase 3: sramWe=1, sramDoe
//    stays 1, FIFO popped) -> IDLE. FIFO empty in phase 2: stay IDLE, bus as READ, Oe=0.
//  - At most one SRAM write per 4-clock frame. Write never overlaps a read phase.
//  - ce arriving while in SETUP/HOLD (irregular ce): the write completes; the read is
//    deferred to the next cycle.
//  - FIFO push: ioctlB & ioctlW. Full and no pop this cycle: byte dropped, overflow<=1
//    (cleared only by reset). Push and pop in same cycle on a full FIFO: both occur.
//    Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - ioctlW while ioctlB=0: ignored.
//  - busy: combinational OR of ioctlB and FIFO non-empty; falls 1 clock after last HOLD.
// CONFIGURATION
//  SRAM_BRIDGE_CKSUM_EN defined: extra port cksum out 8 (reset 0): 8-bit wrap-around sum of
//   every byte actually written to SRAM (counted in HOLD); cleared on rising edge of ioctlB.
//   Not defined: no cksum port, no accumulator logic.
// TESTING
//  1 reset, ce every 4 clocks, vidA=0x1234, model returns 0xA5 -> sramA=0x1234 in phases 0-1,
//    vidQ=0xA5 3 clocks after ce, sramWe never low.
//  2 ioctlB=1, one ioctlW A=0x0010 D=0x3C -> one write in next WRITE slot: sramWe=0 exactly 1
//    clock, sramA=0x0010, sramDo=0x3C, sramDoe=1 2 clocks; busy falls after HOLD.
//  3 burst of 12 ioctlW on consecutive clocks, DEPTH=8 -> at most 3 pops, bytes dropped,
//    overflow=1 stays set until reset; surviving bytes written in push order.
//  4 assert reset during SETUP -> next edge sramWe=1, sramDoe=0, FIFO empty, busy=0 once ioctlB=0.
//  5 ioctlW with ioctlB=0 -> FIFO unchanged, no SRAM write.
//  6 (CKSUM_EN) write 0x80,0x90,0x10 -> cksum=0x20; new ioctlB rising edge -> cksum=0.

Source files
------------

// File: rtl/sram_bridge_if.sv
// sram_bridge_if: the 8-bit external SRAM bus between the bridge and the memory.
// Signals: sramA address, sramWe/sramOe active-low strobes, sramDo/sramDoe write data
//          and drive enable (tristate built outside), sramDi read data.
// Modports: master = bridge side (drives strobes/address), slave = memory side.
interface sram_bridge_if #(
    parameter int AW = 15
);
    logic [AW-1:0] sramA;
    logic          sramWe;
    logic          sramOe;
    logic [7:0]    sramDo;
    logic          sramDoe;
    logic [7:0]    sramDi;

    modport master (
        output sramA, sramWe, sramOe, sramDo, sramDoe,
        input  sramDi
    );

    modport slave (
        input  sramA, sramWe, sramOe, sramDo, sramDoe,
        output sramDi
    );
endinterface

// File: rtl/sram_bridge.sv
// sram_bridge: shares one 8-bit SRAM between the download writer and the video reader.
// Latency: ce -> vidQ valid 3 clocks; a queued byte reaches SRAM in the next free write slot.
// Backpressure: none upstream; bytes arriving on a full FIFO are dropped and flagged sticky in overflow.
// Ports: clock/reset (sync, active high), ce video strobe, ioctl* download byte stream,
//        vidA/vidQ video fetch, sram (SRAM bus interface, master side), busy, overflow.
// Optional: define SRAM_BRIDGE_CKSUM_EN to add output cksum (sum of bytes written to SRAM).
module sram_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          ioctlB,
    input  logic          ioctlW,
    input  logic [AW-1:0] ioctlA,
    input  logic [7:0]    ioctlQ,
    input  logic [AW-1:0] vidA,
    output logic [7:0]    vidQ,
    sram_bridge_if.master sram,
    output logic          busy,
    output logic          overflow
`ifdef SRAM_BRIDGE_CKSUM_EN
    ,
    output logic [7:0]    cksum
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, HOLD} wstate_t;

    // ---------------- download FIFO ----------------
    logic [AW-1:0] fifo_a [DEPTH];
    logic [7:0]    fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, full, push_req, push, pop;

    wstate_t       state, state_nxt;
    logic [1:0]    phase, phase_nxt;
    logic          pend;          // ce seen during SETUP: read starts after HOLD
    logic          start_read;
    logic [AW-1:0] vid_addr;
    logic [AW-1:0] a_nxt;
    logic [7:0]    do_nxt;
    logic          we_nxt, oe_nxt, doe_nxt;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign push_req = ioctlB & ioctlW;
    assign pop      = (state == HOLD);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push     = push_req & (~full | pop);
    assign busy     = ioctlB | ~empty;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a[wr_ptr] <= ioctlA;
            fifo_d[wr_ptr] <= ioctlQ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    // ---------------- frame phase and write FSM ----------------
    // Outputs are registered from the next-cycle phase/state so the bus
    // pins line up with the phase they belong to.
    always_comb begin
        start_read = (ce && state != SETUP) || pend;
        if (start_read)         phase_nxt = 2'd0;
        else if (phase == 2'd3) phase_nxt = 2'd3;
        else                    phase_nxt = phase + 2'd1;

        state_nxt = IDLE;
        case (state)
            IDLE:    if (phase_nxt == 2'd2 && !empty) state_nxt = SETUP;
            SETUP:   state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase

        a_nxt   = sram.sramA;
        do_nxt  = sram.sramDo;
        we_nxt  = 1'b1;
        oe_nxt  = 1'b0;
        doe_nxt = 1'b0;
        if (phase_nxt < 2'd2) a_nxt = ce ? vidA : vid_addr;
        case (state_nxt)
            SETUP: begin
                a_nxt   = fifo_a[rd_ptr];
                do_nxt  = fifo_d[rd_ptr];
                we_nxt  = 1'b0;
                oe_nxt  = 1'b1;
                doe_nxt = 1'b1;
            end
            HOLD: begin
                oe_nxt  = 1'b1;
                doe_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase        <= 2'd3;
            state        <= IDLE;
            pend         <= 1'b0;
            vid_addr     <= '0;
            vidQ         <= 8'h00;
            sram.sramA   <= '0;
            sram.sramWe  <= 1'b1;
            sram.sramOe  <= 1'b0;
            sram.sramDo  <= 8'h00;
            sram.sramDoe <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            state        <= state_nxt;
            pend         <= ce && (state == SETUP);
            if (ce) vid_addr <= vidA;
            if (phase == 2'd1) vidQ <= sram.sramDi;
            sram.sramA   <= a_nxt;
            sram.sramWe  <= we_nxt;
            sram.sramOe  <= oe_nxt;
            sram.sramDo  <= do_nxt;
            sram.sramDoe <= doe_nxt;
        end
    end

`ifdef SRAM_BRIDGE_CKSUM_EN
    logic ioctlB_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cksum    <= 8'h00;
            ioctlB_q <= 1'b0;
        end else begin
            ioctlB_q <= ioctlB;
            if (ioctlB && !ioctlB_q) cksum <= 8'h00;
            else if (state == HOLD)  cksum <= cksum + sram.sramDo;
        end
    end
`endif
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed stimulus with scoreboard queues for video reads and SRAM writes.
// Latency: reads expected 3 clocks after ce; writes expected in push order.
// Backpressure: bytes expected to be dropped on a full FIFO are simply not queued.
module tb_sram_bridge;
    localparam int AW = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic          ioctlB = 1'b0;
    logic          ioctlW = 1'b0;
    logic [AW-1:0] ioctlA = '0;
    logic [7:0]    ioctlQ = 8'h00;
    logic [AW-1:0] vidA = '0;
    logic [7:0]    vidQ;
    logic          busy, overflow;
`ifdef SRAM_BRIDGE_CKSUM_EN
    logic [7:0]    cksum;
`endif

    sram_bridge_if #(.AW(AW)) sram_bus ();

    sram_bridge #(.DEPTH(8), .AW(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .ioctlB   (ioctlB),
        .ioctlW   (ioctlW),
        .ioctlA   (ioctlA),
        .ioctlQ   (ioctlQ),
        .vidA     (vidA),
        .vidQ     (vidQ),
        .sram     (sram_bus),
        .busy     (busy),
        .overflow (overflow)
`ifdef SRAM_BRIDGE_CKSUM_EN
        ,
        .cksum    (cksum)
`endif
    );

    always #5 clock = ~clock;

    // SRAM model: only address 0x1234 holds data (0xA5); reads need Oe low.
    assign sram_bus.sramDi = (sram_bus.sramOe == 1'b0 && sram_bus.sramA == 15'h1234) ? 8'hA5 : 8'h00;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int c; int a; int d; } rd_t;
    typedef struct { int a; int d; } wr_t;
    rd_t rdq[$];
    wr_t wrq[$];

    bit        ce_en = 1'b0;
    bit        short_ok = 1'b0;
    logic [7:0] vid_exp = 8'hA5;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ce generator: one strobe every 4 clocks; each strobe queues its expected read.
    initial begin
        rd_t e;
        forever begin
            @(posedge clock);
            #1;
            if (ce_en && (cyc % 4 == 0)) begin
                ce = 1'b1;
                e.c = cyc;
                e.a = int'(vidA);
                e.d = int'(vid_exp);
                rdq.push_back(e);
            end else begin
                ce = 1'b0;
            end
        end
    end

    // Read monitor: address during the two read phases, data 3 clocks after ce.
    always @(negedge clock) begin
        rd_t h;
        if (rdq.size() > 0) begin
            h = rdq[0];
            if (cyc == h.c + 1 || cyc == h.c + 2) begin
                chk("rd_addr", int'(sram_bus.sramA), h.a);
                chk("rd_oe", int'(sram_bus.sramOe), 0);
                chk("rd_we", int'(sram_bus.sramWe), 1);
            end else if (cyc == h.c + 3) begin
                chk("vidQ", int'(vidQ), h.d);
                void'(rdq.pop_front());
            end else if (cyc > h.c + 3) begin
                chk("rd_lost", cyc, h.c + 3);
                void'(rdq.pop_front());
            end
        end
    end

    // Write monitor: every We-low cycle must match the next queued byte.
    bit prev_we = 1'b1;
    int doe_run = 0;
    int last_setup = -100;
    always @(negedge clock) begin
        wr_t w;
        if (sram_bus.sramWe == 1'b0) begin
            last_setup = cyc;
            chk("we_width", int'(prev_we), 1);
            chk("wr_oe", int'(sram_bus.sramOe), 1);
            chk("wr_doe", int'(sram_bus.sramDoe), 1);
            chk("wr_pending", int'(wrq.size() > 0), 1);
            if (wrq.size() > 0) begin
                w = wrq.pop_front();
                chk("wr_addr", int'(sram_bus.sramA), w.a);
                chk("wr_data", int'(sram_bus.sramDo), w.d);
            end
        end
        if (sram_bus.sramDoe) begin
            doe_run++;
        end else if (doe_run != 0) begin
            if (!short_ok) chk("doe_width", doe_run, 2);
            doe_run = 0;
        end
        prev_we = sram_bus.sramWe;
    end

    task automatic push_byte(input int a, input int d, input bit expect_wr);
        wr_t w;
        ioctlA = AW'(a);
        ioctlQ = 8'(d);
        ioctlW = 1'b1;
        if (expect_wr) begin
            w.a = a;
            w.d = d;
            wrq.push_back(w);
        end
        tick(1);
        ioctlW = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int k = 0;
        while ((busy || wrq.size() > 0) && k < max) begin
            tick(1);
            k++;
        end
        chk(name, int'(k < max), 1);
    endtask

    initial begin
        int k;
        wr_t w;

        // 1: reset values, then regular video fetches
        reset = 1'b1;
        tick(3);
        chk("rst_vidQ", int'(vidQ), 0);
        chk("rst_sramA", int'(sram_bus.sramA), 0);
        chk("rst_sramWe", int'(sram_bus.sramWe), 1);
        chk("rst_sramOe", int'(sram_bus.sramOe), 0);
        chk("rst_sramDo", int'(sram_bus.sramDo), 0);
        chk("rst_sramDoe", int'(sram_bus.sramDoe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
`ifdef SRAM_BRIDGE_CKSUM_EN
        chk("rst_cksum", int'(cksum), 0);
`endif
        reset = 1'b0;
        vidA = 15'h1234;
        ce_en = 1'b1;
        tick(20);

        // 5: strobe without download active is ignored
        push_byte(16'h0055, 8'h77, 1'b0);
        chk("t5_busy", int'(busy), 0);
        tick(12);
        chk("t5_busy_late", int'(busy), 0);

        // 2: single byte
        ioctlB = 1'b1;
        tick(1);
        push_byte(16'h0010, 8'h3C, 1'b1);
        ioctlB = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            tick(1);
            k++;
        end
        chk("t2_busy_timeout", int'(k < 20), 1);
        chk("t2_busy_fall", cyc, last_setup + 2);
        chk("t2_wrq_empty", wrq.size(), 0);

        // 3: 12-byte burst into an 8-deep FIFO aligned to ce: bytes 11 and 12 drop
        while (cyc % 4 != 0) tick(1);
        ioctlB = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            ioctlA = AW'(16'h0100 + i);
            ioctlQ = 8'(8'h40 + i);
            ioctlW = 1'b1;
            if (i <= 10) begin
                w.a = 16'h0100 + i;
                w.d = 8'h40 + i;
                wrq.push_back(w);
            end
            tick(1);
        end
        ioctlW = 1'b0;
        chk("t3_overflow", int'(overflow), 1);
        ioctlB = 1'b0;
        wait_drain("t3_drain_timeout", 80);
        chk("t3_overflow_sticky", int'(overflow), 1);
        chk("t3_busy", int'(busy), 0);

        // 4: reset during SETUP aborts the write and flushes the FIFO
        ioctlB = 1'b1;
        push_byte(16'h0200, 8'h5A, 1'b1);
        short_ok = 1'b1;
        k = 0;
        while (sram_bus.sramWe !== 1'b0 && k < 20) begin
            tick(1);
            k++;
        end
        chk("t4_setup_seen", int'(k < 20), 1);
        reset = 1'b1;
        ce_en = 1'b0;
        ioctlB = 1'b0;
        tick(1);
        chk("t4_sramWe", int'(sram_bus.sramWe), 1);
        chk("t4_sramDoe", int'(sram_bus.sramDoe), 0);
        chk("t4_sramOe", int'(sram_bus.sramOe), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_overflow_clr", int'(overflow), 0);
        chk("t4_vidQ", int'(vidQ), 0);
        reset = 1'b0;
        tick(6);
        chk("t4_busy_after", int'(busy), 0);
        short_ok = 1'b0;
        ce_en = 1'b1;
        tick(8);

`ifdef SRAM_BRIDGE_CKSUM_EN
        // 6: checksum of written bytes, cleared on a new download
        ioctlB = 1'b1;
        tick(1);
        push_byte(16'h0020, 8'h80, 1'b1);
        tick(1);
        push_byte(16'h0021, 8'h90, 1'b1);
        tick(1);
        push_byte(16'h0022, 8'h10, 1'b1);
        ioctlB = 1'b0;
        wait_drain("t6_drain_timeout", 60);
        chk("t6_cksum", int'(cksum), 8'h20);
        tick(2);
        ioctlB = 1'b1;
        tick(1);
        chk("t6_cksum_clr", int'(cksum), 0);
        ioctlB = 1'b0;
        tick(4);
`endif

        ce_en = 1'b0;
        tick(8);
        chk("end_rdq_empty", rdq.size(), 0);
        chk("end_wrq_empty", wrq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
